fetch_issue: RTL

- Instruction fetch and field-split stage that produces the `op`/`funct` fields consumed by the control decoder.
- Consumes the decoder's `pcsrc` result.
- Owns the PC, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and holds it in an instruction register (IR).
- Presents the decoded fields to downstream logic and computes the next PC: sequential or branch.

---
 rtl/fetch_issue_if.sv | 23 ++
 rtl/fetch_issue.sv | 89 ++++++++
 2 files changed

// File: rtl/fetch_issue_if.sv
// Instruction memory fetch bus: request/address from the fetch stage, ack/data back from memory.
interface fetch_issue_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_issue.sv
// Instruction fetch and field split: owns the PC, fetches one word per instruction over a
// req/ack handshake into the IR, issues the decoded fields and selects the next PC.
module fetch_issue #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  fetch_issue_if.master     imem,
  input  logic              stall,
  input  logic              pcsrc,
  output logic              instr_valid,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_plus4
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic              load_ir;
  logic              retire;

  // Word offset of a branch: sign-extend the 16-bit immediate to ADDR_W, then scale by 4.
  function automatic logic signed [ADDR_W-1:0] branch_offset(input logic [15:0] imm16);
    logic signed [ADDR_W-1:0] ext;
    ext = {{(ADDR_W-16){imm16[15]}}, imm16};
    return ext <<< 2;
  endfunction

  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] seq_pc,
                                                      input logic [15:0]       imm16);
    return seq_pc + $unsigned(branch_offset(imm16));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (imem.imem_ack) state_nxt = ISSUE;
      ISSUE:   if (!stall)        state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Request is gated by reset so it stays low while reset is held, independent of state.
  always_comb begin
    imem.imem_req = (state == FETCH) && reset;
    instr_valid   = (state == ISSUE);
    load_ir       = (state == FETCH) && imem.imem_ack;
    retire        = (state == ISSUE) && !stall;
  end

  // PC and IR only move on a fetch ack or a retiring issue; pcsrc matters only when retiring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (load_ir) ir <= imem.imem_rdata;
      if (retire)  pc <= pcsrc ? branch_target(pc_plus4, ir[15:0]) : pc_plus4;
    end
  end

  always_comb begin
    imem.imem_addr = pc;
    pc_plus4       = pc + ADDR_W'(4);
    op             = ir[31:26];
    rs             = ir[25:21];
    rt             = ir[20:16];
    rd             = ir[15:11];
    funct          = ir[5:0];
    imm            = ir[15:0];
  end

endmodule
